// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the 5-stage core. It sits beside the ID/EX
// and EX/MEM registers and resolves the hazards that operand forwarding cannot
// cover. In priority order these are:
//   1. data-memory wait states
//   2. multi-cycle MDU operations
//   3. taken-branch redirects
//   4. load-use dependencies
//
// Optional build macro:
//   HAZARD_PERF_EN - adds saturating stall/flush performance counters.
//                    Without it, both counter outputs are tied to zero.
//
// Parameters:
//   CNT_W - performance counter width
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   id_rs1_addr_i/_rs2_    source register addresses of the ID instruction
//   id_uses_rs1_i/_rs2_    ID instruction actually reads rs1 / rs2
//   ex_rd_i                destination register of the EX instruction
//   ex_mem_read_i          EX instruction is a load
//   ex_branch_taken_i      EX resolved a taken branch/jump
//   ex_mdu_start_i         one-cycle pulse: MDU op issued in EX
//   mdu_done_i             one-cycle pulse: MDU result valid
//   dmem_wait_i            data memory not ready this cycle
//   *_stall_o / *_flush_o  hold / clear enables for PC, IF/ID, ID/EX, EX/MEM
//   mdu_busy_o             waiting on an MDU result
//   stall_cycles_o         cycles with PC held (perf build only)
//   flush_count_o          cycles with any flush (perf build only)
// -----------------------------------------------------------------------------
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_branch_taken_i,
   input  logic             ex_mdu_start_i,
   input  logic             mdu_done_i,
   input  logic             dmem_wait_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_stall_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_stall_o,
   output logic             ex_mem_flush_o,
   output logic             mdu_busy_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   typedef enum logic [0:0] {
      S_RUN      = 1'b0,
      S_MDU_WAIT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_done_seen;
   logic   w_done_seen_nxt;
   logic   w_done_any;
   logic   w_mdu_busy;
   logic   w_mdu_wait_eff;
   logic   w_load_use;

   // A done pulse that arrives during a memory freeze is remembered in
   // done_seen, so the FSM can leave MDU_WAIT once memory is ready again.
   assign w_done_any     = mdu_done_i | r_done_seen;
   assign w_mdu_busy     = (r_state == S_MDU_WAIT) & ~w_done_any;
   // The issue cycle of the MDU op stalls too, before the FSM has moved.
   assign w_mdu_wait_eff = ex_mdu_start_i | w_mdu_busy;

   // Writes to x0 never create a dependency.
   assign w_load_use = ex_mem_read_i & (ex_rd_i != 5'd0) &
                       ((id_uses_rs1_i & (ex_rd_i == id_rs1_addr_i)) |
                        (id_uses_rs2_i & (ex_rd_i == id_rs2_addr_i)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_RUN;
         r_done_seen <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_done_seen <= w_done_seen_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_done_seen_nxt = r_done_seen;
      case (r_state)
         S_RUN: begin
            // A done pulse seen in RUN is ignored.
            if (ex_mdu_start_i) begin
               w_state_nxt = S_MDU_WAIT;
            end
         end
         S_MDU_WAIT: begin
            if (w_done_any && !dmem_wait_i) begin
               w_state_nxt     = S_RUN;
               w_done_seen_nxt = 1'b0;
            end else if (mdu_done_i && dmem_wait_i) begin
               w_done_seen_nxt = 1'b1;
            end
         end
      endcase
   end

   // Exactly one case applies per cycle. Outputs are forced low while reset
   // is asserted.
   always_comb begin
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_stall_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_stall_o = 1'b0;
      ex_mem_flush_o = 1'b0;
      mdu_busy_o     = rst_ni & w_mdu_busy;
      if (rst_ni) begin
         if (dmem_wait_i) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
         end else if (w_mdu_wait_eff) begin
            // Freeze the front of the pipe and feed bubbles into MEM.
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
         end else if (ex_branch_taken_i) begin
            // Squashing the consumer also removes any load-use dependency.
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
         end else if (w_load_use) begin
            // One bubble is enough; forwarding from MEM covers the rest.
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_flush_any;

   assign w_flush_any = if_id_flush_o | id_ex_flush_o | ex_mem_flush_o;

   // Both counters saturate at all-ones and do not wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_stall_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush_any && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cycles_o = r_stall_cnt;
   assign flush_count_o  = r_flush_cnt;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       u1 = 0, u2 = 0, mrd = 0, br = 0, start = 0, done = 0, dwait = 0;

   logic        a_pcs, a_ifs, a_iff, a_ids, a_idf, a_ems, a_emf, a_busy;
   logic [31:0] a_sc, a_fc;
   logic        b_pcs, b_ifs, b_iff, b_ids, b_idf, b_ems, b_emf, b_busy;
   logic [3:0]  b_sc, b_fc;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   bit          m_waiting;   // an MDU op is outstanding
   bit          m_latched;   // its result arrived during a memory freeze
   longint      m_sc_a, m_fc_a, m_sc_b, m_fc_b;

   always #5 clk = ~clk;

   hazard_unit #(.CNT_W(32)) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_rd_i(rd), .ex_mem_read_i(mrd), .ex_branch_taken_i(br),
      .ex_mdu_start_i(start), .mdu_done_i(done), .dmem_wait_i(dwait),
      .pc_stall_o(a_pcs), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff),
      .id_ex_stall_o(a_ids), .id_ex_flush_o(a_idf),
      .ex_mem_stall_o(a_ems), .ex_mem_flush_o(a_emf),
      .mdu_busy_o(a_busy), .stall_cycles_o(a_sc), .flush_count_o(a_fc)
   );

   hazard_unit #(.CNT_W(4)) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_rd_i(rd), .ex_mem_read_i(mrd), .ex_branch_taken_i(br),
      .ex_mdu_start_i(start), .mdu_done_i(done), .dmem_wait_i(dwait),
      .pc_stall_o(b_pcs), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff),
      .id_ex_stall_o(b_ids), .id_ex_flush_o(b_idf),
      .ex_mem_stall_o(b_ems), .ex_mem_flush_o(b_emf),
      .mdu_busy_o(b_busy), .stall_cycles_o(b_sc), .flush_count_o(b_fc)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Flags packed as {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
   //                  id_ex_flush, ex_mem_stall, ex_mem_flush, mdu_busy}
   function automatic logic [7:0] model_out();
      bit busy, mdu_hold, dep;
      busy     = m_waiting && !(done || m_latched);
      mdu_hold = start || busy;
      dep      = mrd && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      if (dwait)         return {7'b1101010, busy};
      else if (mdu_hold) return {7'b1101001, busy};
      else if (br)       return {7'b0010100, busy};
      else if (dep)      return {7'b1100100, busy};
      else               return {7'b0000000, busy};
   endfunction

   function automatic logic [7:0] flags_a();
      return {a_pcs, a_ifs, a_iff, a_ids, a_idf, a_ems, a_emf, a_busy};
   endfunction

   function automatic logic [7:0] flags_b();
      return {b_pcs, b_ifs, b_iff, b_ids, b_idf, b_ems, b_emf, b_busy};
   endfunction

   function automatic longint sat_inc(input longint v, input longint cap);
      return (v >= cap) ? cap : v + 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] o;
      if (!rst_n) begin
         m_waiting = 0; m_latched = 0;
         m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
      end else begin
         o = model_out();
`ifdef HAZARD_PERF_EN
         if (o[7]) begin
            m_sc_a = sat_inc(m_sc_a, 64'hFFFF_FFFF);
            m_sc_b = sat_inc(m_sc_b, 15);
         end
         if (o[5] || o[3] || o[1]) begin
            m_fc_a = sat_inc(m_fc_a, 64'hFFFF_FFFF);
            m_fc_b = sat_inc(m_fc_b, 15);
         end
`endif
         if (!m_waiting) begin
            if (start) m_waiting = 1;
         end else if ((done || m_latched) && !dwait) begin
            m_waiting = 0; m_latched = 0;
         end else if (done && dwait) begin
            m_latched = 1;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      logic [7:0] e;
      e = rst_n ? model_out() : 8'h00;
      check("flags_a", {56'd0, flags_a()}, {56'd0, e});
      check("flags_b", {56'd0, flags_b()}, {56'd0, e});
      check("stall_cnt_a", {32'd0, a_sc}, m_sc_a);
      check("flush_cnt_a", {32'd0, a_fc}, m_fc_a);
      check("stall_cnt_b", {60'd0, b_sc}, m_sc_b);
      check("flush_cnt_b", {60'd0, b_fc}, m_fc_b);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mrd = 0;
      br = 0; start = 0; done = 0; dwait = 0;
   endtask

   task automatic load_use();
      idle(); mrd = 1; rd = 5'd5; rs2 = 5'd5; u2 = 1;
   endtask

   initial begin
      int n_stall, n_busy;
      idle();
      #12 rst_n = 1'b1;
      step();
      #2 check("reset_idle", {56'd0, flags_a()}, 64'h00);

      // performance counters: 3 load-use bubbles + 1 branch
      for (int k = 0; k < 3; k++) begin
         step(); load_use();
         #2 check("lu_perf", {56'd0, flags_a()}, 64'hC8);
         step(); idle();
      end
      step(); idle(); br = 1;
      step(); idle();
      #2;
`ifdef HAZARD_PERF_EN
      check("perf_stall3", {32'd0, a_sc}, 64'd3);
      check("perf_flush4", {32'd0, a_fc}, 64'd4);
`else
      check("perf_stall_off", {32'd0, a_sc}, 64'd0);
      check("perf_flush_off", {32'd0, a_fc}, 64'd0);
`endif
      for (int k = 0; k < 20; k++) begin
         step(); idle(); dwait = 1;
      end
      step(); idle();
      #2;
`ifdef HAZARD_PERF_EN
      check("perf_sat_b", {60'd0, b_sc}, 64'd15);
      check("perf_a23", {32'd0, a_sc}, 64'd23);
`else
      check("perf_sat_off", {60'd0, b_sc}, 64'd0);
`endif

      // load-use, then same with rd = x0
      step(); load_use();
      #2 check("load_use", {56'd0, flags_a()}, 64'hC8);
      step(); load_use(); rd = 0; rs2 = 0;
      #2 check("lu_rd0", {56'd0, flags_a()}, 64'h00);

      // branch overrides load-use
      step(); load_use(); br = 1;
      #2 check("br_vs_lu", {56'd0, flags_a()}, 64'h28);

      // MDU: start, result five cycles after issue
      n_stall = 0; n_busy = 0;
      for (int c = 0; c < 6; c++) begin
         step(); idle();
         start = (c == 0);
         done  = (c == 5);
         #2;
         n_stall += a_pcs;
         n_busy  += a_busy;
      end
      check("mdu_stall5", n_stall, 5);
      check("mdu_busy4", n_busy, 4);
      step(); idle();
      #2 check("mdu_back_run", {56'd0, flags_a()}, 64'h00);

      // done pulse during a 3-cycle memory freeze
      step(); idle(); start = 1;
      #2 check("mdu_issue", {56'd0, flags_a()}, 64'hD2);
      step(); idle();
      #2 check("mdu_wait", {56'd0, flags_a()}, 64'hD3);
      for (int c = 0; c < 3; c++) begin
         step(); idle(); dwait = 1; done = (c == 0);
         #2 check("freeze", {56'd0, flags_a()}, 64'hD4);
      end
      step(); idle();
      #2 check("freeze_release", {56'd0, flags_a()}, 64'h00);
      step(); idle();
      #2 check("freeze_run", {56'd0, flags_a()}, 64'h00);

      // asynchronous reset in MDU_WAIT
      step(); idle(); start = 1;
      step(); idle();
      #1 rst_n = 1'b0;
      #1 check("async_rst", {56'd0, flags_a()}, 64'h00);
      step(); step();
      #3 rst_n = 1'b1;
      step(); idle();
      #2 check("post_rst_run", {56'd0, flags_a()}, 64'h00);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         step();
         rs1   = 5'($urandom_range(0, 3));
         rs2   = 5'($urandom_range(0, 3));
         rd    = 5'($urandom_range(0, 3));
         u1    = 1'($urandom_range(0, 1));
         u2    = 1'($urandom_range(0, 1));
         mrd   = ($urandom_range(0, 99) < 40);
         br    = ($urandom_range(0, 99) < 15);
         start = ($urandom_range(0, 99) < 6);
         done  = ($urandom_range(0, 99) < 15);
         dwait = ($urandom_range(0, 99) < 20);
      end
      step(); idle();
      step();
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
